ps2_scancode_receiver: RTL and testbench

- Front-end keyboard stage that feeds the VGA control block.
- Synchronises the PS/2 keyboard clock and data lines (clk_kb, data_kb) into the system Clock domain and deserialises 11-bit PS/2 frames.
- Checks start, odd-parity and stop bits, and folds the E0 and F0 prefixes into flags.
- Produces one registered scancode event per key make/break for the downstream character/draw logic.

---
 rtl/ps2_scancode_receiver_if.sv | 20 ++
 rtl/ps2_scancode_receiver.sv | 168 ++++++++++++++++
 tb/tb_ps2_scancode_receiver.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scancode_receiver_if.sv
// Keyboard-side bundle: raw PS/2 lines in, decoded scancode events out.
interface ps2_scancode_receiver_if;
  logic       clk_kb;
  logic       data_kb;
  logic [7:0] oScanCode;
  logic       oCodeValid;
  logic       oBreak;
  logic       oExtended;
  logic       oFrameError;

  modport master (
    output clk_kb, data_kb,
    input  oScanCode, oCodeValid, oBreak, oExtended, oFrameError
  );

  modport slave (
    input  clk_kb, data_kb,
    output oScanCode, oCodeValid, oBreak, oExtended, oFrameError
  );
endinterface

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: synchronises the keyboard lines, deserialises 11-bit frames,
// folds E0/F0 prefixes into flags and emits one registered event per make/break code.
module ps2_scancode_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input logic                   Clock,
  input logic                   Reset,
  ps2_scancode_receiver_if.slave kb
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   fall_s, data_s;

  state_e      state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        brk_pend_q, brk_pend_d, ext_pend_q, ext_pend_d;
  logic [7:0]  code_q, code_d;
  logic        brk_q, brk_d, ext_q, ext_d, valid_q, valid_d, err_q, err_d;

  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall_s = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

  // Synchroniser chains; idle-high reset so no spurious fall leaves reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], kb.clk_kb};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], kb.data_kb};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= 3'd0;
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      brk_pend_q <= 1'b0;
      ext_pend_q <= 1'b0;
      code_q     <= 8'h00;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
      brk_pend_q <= brk_pend_d;
      ext_pend_q <= ext_pend_d;
      code_q     <= code_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tmo_d      = tmo_q;
    brk_pend_d = brk_pend_q;
    ext_pend_d = ext_pend_q;
    code_d     = code_q;
    brk_d      = brk_q;
    ext_d      = ext_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    if (state_q == S_IDLE || fall_s) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (fall_s && !data_s) begin
          state_d  = S_DATA;
          bitcnt_d = 3'd0;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_DATA: begin
        if (fall_s) begin
          shift_d  = {data_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          state_d  = (bitcnt_q == 3'd7) ? S_PARITY : S_DATA;
        end else begin
          state_d  = S_DATA;
        end
      end
      S_PARITY: begin
        if (fall_s) begin
          parity_d = data_s;
          state_d  = S_STOP;
        end else begin
          state_d  = S_PARITY;
        end
      end
      S_STOP: begin
        if (fall_s) begin
          state_d = S_IDLE;
          if (data_s && (^{shift_q, parity_q})) begin
            if (shift_q == 8'hF0) begin
              brk_pend_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
              ext_pend_d = 1'b1;
            end else begin
              code_d     = shift_q;
              brk_d      = brk_pend_q;
              ext_d      = ext_pend_q;
              valid_d    = 1'b1;
              brk_pend_d = 1'b0;
              ext_pend_d = 1'b0;
            end
          end else begin
            err_d      = 1'b1;
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A fall event in the expiry cycle keeps the frame alive.
    if (state_q != S_IDLE && !fall_s && tmo_q == TMO_LAST) begin
      state_d    = S_IDLE;
      err_d      = 1'b1;
      brk_pend_d = 1'b0;
      ext_pend_d = 1'b0;
      tmo_d      = '0;
    end else begin
      state_d    = state_d;
    end
  end

  assign kb.oScanCode   = code_q;
  assign kb.oCodeValid  = valid_q;
  assign kb.oBreak      = brk_q;
  assign kb.oExtended   = ext_q;
  assign kb.oFrameError = err_q;
endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Self-checking bench: directed scenarios plus a randomized byte stream scored
// against a byte-level model of the prefix/flag rules.
module tb_ps2_scancode_receiver;
  localparam int SYNC = 2;
  localparam int TMO  = 2000;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  ps2_scancode_receiver_if kb ();

  ps2_scancode_receiver #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .Clock(Clock), .Reset(Reset), .kb(kb)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  int valid_cnt = 0, err_cnt = 0, last_valid_cyc = 0, last_err_cyc = 0;
  int fall_cyc = 0;
  int n_cmp = 0, n_bad = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (kb.oCodeValid === 1'b1) begin valid_cnt++; last_valid_cyc = cyc; end
    if (kb.oFrameError === 1'b1) begin err_cnt++; last_err_cyc = cyc; end
  end

  task automatic send_bit(input logic b, input int h);
    kb.data_kb = b;
    repeat (h) @(negedge Clock);
    kb.clk_kb = 1'b0;
    fall_cyc = cyc;
    repeat (h) @(negedge Clock);
    kb.clk_kb = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input int h);
    send_bit(1'b0, h);
    for (int i = 0; i < 8; i++) send_bit(b[i], h);
    send_bit(par, h);
    send_bit(stp, h);
    kb.data_kb = 1'b1;
    repeat (SYNC + 4) @(negedge Clock);
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    n_cmp++; if (kb.oScanCode !== 8'h00) begin n_bad++; $display("FAIL reset_code got=%h exp=00", kb.oScanCode); end
    n_cmp++; if ({kb.oCodeValid, kb.oBreak, kb.oExtended, kb.oFrameError} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags got=%b exp=0000", {kb.oCodeValid, kb.oBreak, kb.oExtended, kb.oFrameError}); end
  endtask

  task automatic test_basic();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h22, 1'b1, 1'b1, 8);
    n_cmp++; if (valid_cnt - v0 !== 1) begin n_bad++; $display("FAIL basic_valid got=%0d exp=1", valid_cnt - v0); end
    n_cmp++; if (last_valid_cyc - fall_cyc !== SYNC + 1) begin n_bad++; $display("FAIL basic_latency got=%0d exp=%0d", last_valid_cyc - fall_cyc, SYNC + 1); end
    n_cmp++; if ({kb.oScanCode, kb.oBreak, kb.oExtended} !== {8'h22, 2'b00}) begin
      n_bad++; $display("FAIL basic_out got=%h/%b%b exp=22/00", kb.oScanCode, kb.oBreak, kb.oExtended); end
    n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL basic_err got=%0d exp=0", err_cnt - e0); end
  endtask

  task automatic test_break();
    int v0;
    v0 = valid_cnt;
    send_frame(8'hF0, 1'b1, 1'b1, 6);
    n_cmp++; if (valid_cnt - v0 !== 0) begin n_bad++; $display("FAIL brk_prefix_valid got=%0d exp=0", valid_cnt - v0); end
    send_frame(8'h22, 1'b1, 1'b1, 6);
    n_cmp++; if (valid_cnt - v0 !== 1 || kb.oScanCode !== 8'h22 || kb.oBreak !== 1'b1) begin
      n_bad++; $display("FAIL brk_code got=%0d/%h/%b exp=1/22/1", valid_cnt - v0, kb.oScanCode, kb.oBreak); end
    send_frame(8'h22, 1'b1, 1'b1, 6);
    n_cmp++; if (valid_cnt - v0 !== 2 || kb.oBreak !== 1'b0) begin
      n_bad++; $display("FAIL brk_clear got=%0d/%b exp=2/0", valid_cnt - v0, kb.oBreak); end
  endtask

  task automatic test_ext_break();
    int v0;
    v0 = valid_cnt;
    send_frame(8'hE0, 1'b0, 1'b1, 5);
    send_frame(8'hF0, 1'b1, 1'b1, 5);
    n_cmp++; if (valid_cnt - v0 !== 0) begin n_bad++; $display("FAIL ext_prefix_valid got=%0d exp=0", valid_cnt - v0); end
    send_frame(8'h74, 1'b1, 1'b1, 5);
    n_cmp++; if ({kb.oScanCode, kb.oExtended, kb.oBreak} !== {8'h74, 2'b11} || valid_cnt - v0 !== 1) begin
      n_bad++; $display("FAIL ext_code got=%h/%b%b exp=74/11", kb.oScanCode, kb.oExtended, kb.oBreak); end
    send_frame(8'h74, 1'b1, 1'b1, 5);
    n_cmp++; if ({kb.oExtended, kb.oBreak} !== 2'b00) begin
      n_bad++; $display("FAIL ext_clear got=%b%b exp=00", kb.oExtended, kb.oBreak); end
  endtask

  task automatic test_errors();
    int v0, e0;
    logic [7:0] prev;
    prev = kb.oScanCode;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h22, 1'b0, 1'b1, 7);
    n_cmp++; if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin
      n_bad++; $display("FAIL err_parity got=%0d/%0d exp=1/0", err_cnt - e0, valid_cnt - v0); end
    send_frame(8'h22, 1'b1, 1'b0, 7);
    n_cmp++; if (err_cnt - e0 !== 2 || valid_cnt - v0 !== 0 || kb.oScanCode !== prev) begin
      n_bad++; $display("FAIL err_stop got=%0d/%0d/%h exp=2/0/%h", err_cnt - e0, valid_cnt - v0, kb.oScanCode, prev); end
    send_frame(8'h1C, 1'b0, 1'b1, 7);
    n_cmp++; if (valid_cnt - v0 !== 1 || kb.oScanCode !== 8'h1C || err_cnt - e0 !== 2) begin
      n_bad++; $display("FAIL err_recover got=%0d/%h exp=1/1c", valid_cnt - v0, kb.oScanCode); end
  endtask

  task automatic test_timeout();
    int e0, v0, start;
    logic [7:0] b;
    b = 8'h22;
    e0 = err_cnt; v0 = valid_cnt;
    send_bit(1'b0, 6);
    for (int i = 0; i < 3; i++) send_bit(b[i], 6);
    kb.data_kb = 1'b1;
    start = fall_cyc;
    while (cyc < start + TMO - 2) @(negedge Clock);
    n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL tmo_early got=%0d exp=0", err_cnt - e0); end
    repeat (SYNC + 8) @(negedge Clock);
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL tmo_pulse got=%0d exp=1", err_cnt - e0); end
    n_cmp++; if (last_err_cyc - start < TMO || last_err_cyc - start > TMO + SYNC + 3) begin
      n_bad++; $display("FAIL tmo_time got=%0d exp=%0d..%0d", last_err_cyc - start, TMO, TMO + SYNC + 3); end
    send_frame(8'h22, 1'b1, 1'b1, 6);
    n_cmp++; if (valid_cnt - v0 !== 1 || kb.oScanCode !== 8'h22) begin
      n_bad++; $display("FAIL tmo_recover got=%0d/%h exp=1/22", valid_cnt - v0, kb.oScanCode); end
  endtask

  task automatic test_midframe_reset();
    int v0, e0;
    logic [7:0] b;
    send_frame(8'h22, 1'b1, 1'b1, 6);
    b = 8'hE1;  // upper data bits, parity and stop all 1: the remainder is idle-level
    send_bit(1'b0, 6);
    for (int i = 0; i < 5; i++) send_bit(b[i], 6);
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    n_cmp++; if ({kb.oScanCode, kb.oCodeValid, kb.oBreak, kb.oExtended, kb.oFrameError} !== 12'h000) begin
      n_bad++; $display("FAIL rst_mid_out got=%h exp=000", {kb.oScanCode, kb.oCodeValid, kb.oBreak, kb.oExtended, kb.oFrameError}); end
    v0 = valid_cnt; e0 = err_cnt;
    for (int i = 5; i < 8; i++) send_bit(b[i], 6);
    send_bit(1'b1, 6);
    send_bit(1'b1, 6);
    repeat (SYNC + 6) @(negedge Clock);
    n_cmp++; if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin
      n_bad++; $display("FAIL rst_mid_quiet got=%0d/%0d exp=0/0", valid_cnt - v0, err_cnt - e0); end
    send_frame(8'h1C, 1'b0, 1'b1, 6);
    n_cmp++; if (valid_cnt - v0 !== 1 || kb.oScanCode !== 8'h1C || kb.oBreak !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_fresh got=%0d/%h exp=1/1c", valid_cnt - v0, kb.oScanCode); end
  endtask

  task automatic test_random();
    logic mb, me, exp_b, exp_e, par, stp;
    logic [7:0] b, exp_code;
    int exp_v, exp_err, v0, e0, k, h;
    mb = 1'b0; me = 1'b0;
    exp_code = kb.oScanCode; exp_b = kb.oBreak; exp_e = kb.oExtended;
    exp_v = 0; exp_err = 0;
    v0 = valid_cnt; e0 = err_cnt;
    for (int n = 0; n < 30; n++) begin
      k = int'($urandom_range(0, 99));
      h = int'($urandom_range(SYNC + 2, 10));
      if (k < 20) b = 8'hF0;
      else if (k < 35) b = 8'hE0;
      else begin
        b = 8'($urandom);
        while (b == 8'hF0 || b == 8'hE0) b = 8'($urandom);
      end
      par = ~(^b); stp = 1'b1;
      if (k >= 88) begin
        if (k[0]) par = ~par; else stp = 1'b0;
        exp_err++; mb = 1'b0; me = 1'b0;
      end else if (b == 8'hF0) mb = 1'b1;
      else if (b == 8'hE0) me = 1'b1;
      else begin
        exp_code = b; exp_b = mb; exp_e = me; exp_v++;
        mb = 1'b0; me = 1'b0;
      end
      send_frame(b, par, stp, h);
      repeat (int'($urandom_range(0, 5))) @(negedge Clock);
      n_cmp++; if (valid_cnt - v0 !== exp_v || err_cnt - e0 !== exp_err) begin
        n_bad++; $display("FAIL rnd_count[%0d] got=%0d/%0d exp=%0d/%0d", n, valid_cnt - v0, err_cnt - e0, exp_v, exp_err); end
      n_cmp++; if ({kb.oScanCode, kb.oBreak, kb.oExtended} !== {exp_code, exp_b, exp_e}) begin
        n_bad++; $display("FAIL rnd_out[%0d] got=%h/%b%b exp=%h/%b%b", n, kb.oScanCode, kb.oBreak, kb.oExtended, exp_code, exp_b, exp_e); end
    end
  endtask

  initial begin
    kb.clk_kb = 1'b1;
    kb.data_kb = 1'b1;
    @(negedge Clock);
    test_reset();
    test_basic();
    test_break();
    test_ext_break();
    test_errors();
    test_timeout();
    test_midframe_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
